// File: rtl/demod_pkg.sv
// ---------------------------------------------------------------------------
// demod_pkg
// Shared constants and types for the demodulator back end.
//   - Fixed-point layout of the resampled I/Q symbols (sign/int/frac widths).
//   - Legal BITS_PER_SYM values (BPSK = 1, QPSK = 2).
//   - QPSK phase-index type and the sign-quadrant to phase-index mapping.
// ---------------------------------------------------------------------------
package demod_pkg;

    localparam int SYM_WIDTH_DEF  = 1;
    localparam int INT_WIDTH_DEF  = 1;
    localparam int DEC_WIDTH_DEF  = 14;
    localparam int DATA_WIDTH_DEF = SYM_WIDTH_DEF + INT_WIDTH_DEF + DEC_WIDTH_DEF;

    localparam int BPS_BPSK = 1;
    localparam int BPS_QPSK = 2;

    // Phase index counts quadrants counter-clockwise from the first quadrant.
    typedef enum logic [1:0] {
        PH_0   = 2'd0,
        PH_90  = 2'd1,
        PH_180 = 2'd2,
        PH_270 = 2'd3
    } qpsk_phase_t;

    function automatic qpsk_phase_t qpsk_phase(input logic i_neg, input logic q_neg);
        case ({i_neg, q_neg})
            2'b00:   return PH_0;
            2'b10:   return PH_90;
            2'b11:   return PH_180;
            default: return PH_270;
        endcase
    endfunction

endpackage

// File: rtl/byte_fifo2.sv
// ---------------------------------------------------------------------------
// byte_fifo2
// Two-entry byte FIFO with a valid/ready read side.
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   push, push_data     write request and byte; ignored when full unless the
//                       same edge also pops
//   full, empty         occupancy flags
//   out_data, out_valid head entry and non-empty flag
//   out_ready           downstream accepts the head entry
// ---------------------------------------------------------------------------
module byte_fifo2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       empty,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    logic [7:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       pop;
    logic       do_push;

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];

    assign pop     = out_valid & out_ready;
    // When full, a simultaneous pop frees the head slot, which is the one
    // wr_ptr points at; the head is read combinationally before it is replaced.
    assign do_push = push & (~full | pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: the storage is reset as well so out_data reads 0 after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= 8'd0;
            mem[1] <= 8'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mpsk_symbol_demapper.sv
// ---------------------------------------------------------------------------
// mpsk_symbol_demapper
// Hard BPSK/QPSK decision on strobed I/Q symbols, optional differential
// decoding, MSB-first byte packing and a 2-entry valid/ready output FIFO.
// Optional feature macro: DEMAP_DIFF_DECODE_EN (differential decoding).
// Ports:
//   clk, rstn                clock, asynchronous active-low reset
//   mk                       symbol strobe
//   InputDataI, InputDataQ   signed symbol samples (only the sign is used)
//   sync_clr                 byte-alignment clear
//   out_data, out_valid,
//   out_ready                packed byte stream
//   overflow                 sticky: a byte was dropped on a full FIFO
//   drop_cnt                 saturating dropped-byte count
// ---------------------------------------------------------------------------
module mpsk_symbol_demapper
    import demod_pkg::*;
#(
    parameter int SYM_WIDTH    = SYM_WIDTH_DEF,
    parameter int INT_WIDTH    = INT_WIDTH_DEF,
    parameter int DEC_WIDTH    = DEC_WIDTH_DEF,
    parameter int BITS_PER_SYM = BPS_QPSK
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   mk,
    input  logic [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] InputDataI,
    input  logic [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] InputDataQ,
    input  logic                                   sync_clr,
    output logic [7:0]                             out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   overflow,
    output logic [7:0]                             drop_cnt
);

    localparam int DATA_WIDTH    = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
    localparam int SYMS_PER_BYTE = 8 / BITS_PER_SYM;
    localparam logic [2:0] LAST_SYM = 3'(SYMS_PER_BYTE - 1);

    generate
        if (BITS_PER_SYM != BPS_BPSK && BITS_PER_SYM != BPS_QPSK) begin : g_bad_bps
            $fatal(1, "mpsk_symbol_demapper: BITS_PER_SYM must be 1 or 2");
        end
    endgenerate

    logic                    i_neg;
    logic                    q_neg;
    logic [BITS_PER_SYM-1:0] sym_bits;
    logic [2:0]              sym_cnt;
    logic [7:0]              pack_reg;
    logic                    push_req;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    drop;
    logic                    unused_mag;

    // Zero has a clear sign bit, so it decides as positive.
    assign i_neg = InputDataI[DATA_WIDTH-1];
    assign q_neg = InputDataQ[DATA_WIDTH-1];
    assign unused_mag = ^{InputDataI[DATA_WIDTH-2:0], InputDataQ[DATA_WIDTH-2:0]};

`ifdef DEMAP_DIFF_DECODE_EN
    logic [1:0]              k_full;
    logic [BITS_PER_SYM-1:0] k;
    logic [BITS_PER_SYM-1:0] k_prev;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        k_full = 2'd0;
        if (BITS_PER_SYM == BPS_BPSK) begin
            k_full = {1'b0, i_neg};
        end else begin
            k_full = 2'(qpsk_phase(i_neg, q_neg));
        end
        k = k_full[BITS_PER_SYM-1:0];
        // Modular subtraction in BITS_PER_SYM bits gives the phase step.
        sym_bits = k - k_prev;
    end

    // The reference follows every strobed symbol, including one that arrives
    // with sync_clr, since byte alignment is unrelated to carrier phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_prev <= '0;
        end else if (mk) begin
            k_prev <= k;
        end
    end
`else
    logic [1:0] dir_full;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        dir_full = 2'd0;
        if (BITS_PER_SYM == BPS_BPSK) begin
            dir_full = {1'b0, i_neg};
        end else begin
            dir_full = {i_neg, q_neg};
        end
        sym_bits = dir_full[BITS_PER_SYM-1:0];
    end
`endif

    // Packing: symbols enter at the LSB so the first one lands in the MSBs.
    // The completed byte stays in pack_reg for the edge that pushes it; a new
    // symbol on that same edge shifts in only after the FIFO has sampled it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sym_cnt  <= 3'd0;
            pack_reg <= 8'd0;
            push_req <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (sync_clr) begin
                if (mk) begin
                    pack_reg <= 8'(sym_bits);
                    sym_cnt  <= 3'd1;
                end else begin
                    pack_reg <= 8'd0;
                    sym_cnt  <= 3'd0;
                end
            end else if (mk) begin
                pack_reg <= {pack_reg[7-BITS_PER_SYM:0], sym_bits};
                if (sym_cnt == LAST_SYM) begin
                    sym_cnt  <= 3'd0;
                    push_req <= 1'b1;
                end else begin
                    sym_cnt <= sym_cnt + 3'd1;
                end
            end
        end
    end

    byte_fifo2 u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_req),
        .push_data (pack_reg),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // A push into a full FIFO is lost only if the same edge does not pop.
    assign drop = push_req & fifo_full & ~(out_valid & out_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
